// File: rtl/majority_vote_n.sv
// Registered N-way bitwise majority voter with per-channel persistence fault flags and a saturating error count.
// Latency 1 cycle, no backpressure; define MAJORITY_MASK_EN to drop faulted channels from the vote.
module majority_vote_n #(
   parameter int N        = 3,
   parameter int W        = 8,
   parameter int FAULT_TH = 4,
   parameter int CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             VALID,
   input  logic [N*W-1:0]   DIN,
   input  logic             CLR_FAULT,
   output logic [W-1:0]     MAJO,
   output logic             MAJO_VALID,
   output logic [N-1:0]     DISAGREE,
   output logic [N-1:0]     FAULT,
   output logic [CNT_W-1:0] ERR_CNT
);

   localparam int PC_W = $clog2(FAULT_TH + 1);

`ifdef MAJORITY_MASK_EN
   localparam bit MASK_EN = 1'b1;
`else
   localparam bit MASK_EN = 1'b0;
`endif

   logic [W-1:0]     w_vote;
   logic [N-1:0]     w_mismatch;
   logic             w_any_mismatch;

   logic [W-1:0]     r_majo;
   logic             r_majo_valid;
   logic [N-1:0]     r_disagree;
   logic [N-1:0]     r_fault;
   logic [CNT_W-1:0] r_err_cnt;
   logic [PC_W-1:0]  r_pc [N];

   // 2*ones > voters is a strict majority; with masking a tie or an empty electorate votes 0.
   always_comb begin
      int ones;
      int voters;
      ones   = 0;
      voters = 0;
      w_vote = '0;
      for (int b = 0; b < W; b++) begin
         ones   = 0;
         voters = 0;
         for (int i = 0; i < N; i++) begin
            if (!MASK_EN || !r_fault[i]) begin
               voters = voters + 1;
               if (DIN[i*W + b]) ones = ones + 1;
            end
         end
         w_vote[b] = (2 * ones > voters);
      end
   end

   always_comb begin
      w_mismatch = '0;
      for (int i = 0; i < N; i++) begin
         w_mismatch[i] = (DIN[i*W +: W] != w_vote);
      end
   end

   assign w_any_mismatch = |w_mismatch;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_majo       <= '0;
         r_majo_valid <= 1'b0;
         r_disagree   <= '0;
         r_fault      <= '0;
         r_err_cnt    <= '0;
         for (int i = 0; i < N; i++) r_pc[i] <= '0;
      end else begin
         r_majo_valid <= VALID;
         if (VALID) begin
            r_majo     <= w_vote;
            r_disagree <= w_mismatch;
         end

         // A clear wins over the bookkeeping of a sample arriving in the same cycle.
         if (CLR_FAULT) begin
            r_fault   <= '0;
            r_err_cnt <= '0;
            for (int i = 0; i < N; i++) r_pc[i] <= '0;
         end else if (VALID) begin
            for (int i = 0; i < N; i++) begin
               if (MASK_EN && r_fault[i]) begin
                  r_pc[i] <= r_pc[i];
               end else if (w_mismatch[i]) begin
                  if (r_pc[i] != PC_W'(FAULT_TH)) r_pc[i] <= r_pc[i] + 1'b1;
                  if (r_pc[i] >= PC_W'(FAULT_TH - 1)) r_fault[i] <= 1'b1;
               end else begin
                  r_pc[i] <= '0;
               end
            end
            if (w_any_mismatch && (r_err_cnt != {CNT_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

   assign MAJO       = r_majo;
   assign MAJO_VALID = r_majo_valid;
   assign DISAGREE   = r_disagree;
   assign FAULT      = r_fault;
   assign ERR_CNT    = r_err_cnt;

endmodule

// File: doc/majority_vote_n.md
Name: majority_vote_n

Overview:
- Parametrised, registered N-way bitwise majority voter for W-bit redundant channels, e.g. TMR datapath outputs.
- Produces a voted word one cycle after each valid sample.
- Tracks per-channel disagreement with a persistence counter and raises a sticky per-channel fault flag.
- Keeps a saturating count of samples with any disagreement.
- Sits between the replicated compute units and the downstream consumer.

Parameters:
- N, 3: number of voting channels; odd, 3..15.
- W, 8: data width per channel, 1..32.
- FAULT_TH, 4: consecutive mismatching valid samples before a channel's FAULT bit sets; 1..255.
- CNT_W, 16: width of ERR_CNT.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- VALID  in  1  DIN holds a sample this cycle.
- DIN  in  N*W  channel i occupies DIN[i*W +: W].
- CLR_FAULT  in  1  synchronous clear of FAULT, persistence counters and ERR_CNT.
- MAJO  out  W  voted word.
- MAJO_VALID  out  1  MAJO is new this cycle.
- DISAGREE  out  N  bit i = channel i differed from the vote for the sample now on MAJO.
- FAULT  out  N  sticky per-channel fault flags.
- ERR_CNT  out  CNT_W  saturating count of samples with DISAGREE != 0.

Behaviour:
- Reset (RST=1, async): all outputs 0, all persistence counters 0. Reset asserted mid-stream discards any in-flight sample.
- Vote: for each bit b, vote[b] = 1 iff the number of channels with bit b = 1 is greater than N/2 (integer division). The vote is combinational from DIN.
- Latency 1 cycle. On a clock edge with VALID=1:
  - MAJO <= vote
  - DISAGREE[i] <= (channel i != vote)
  - MAJO_VALID <= 1
- On a clock edge with VALID=0: MAJO_VALID <= 0. MAJO and DISAGREE hold their previous values.
- Persistence counter per channel, PC[i], width clog2(FAULT_TH+1). Updated only on VALID:
  - mismatch: PC[i] <= min(PC[i]+1, FAULT_TH)
  - match: PC[i] <= 0
- FAULT[i] sets on the edge at which PC[i] reaches FAULT_TH, i.e. the same edge that registers the FAULT_TH-th consecutive mismatch. It stays set while the channel later matches. It clears only on RST or CLR_FAULT.
- ERR_CNT increments by 1 on each VALID sample whose vote has any mismatching channel. It saturates at 2^CNT_W-1 and does not wrap.
- CLR_FAULT=1 in a cycle clears FAULT, all PC and ERR_CNT at that edge. It has priority over the VALID-cycle updates of PC, FAULT and ERR_CNT: the sample is voted and MAJO, DISAGREE and MAJO_VALID update normally, but it is not counted.
- Unanimous sample: DISAGREE = 0, no counter changes except PC reset to 0.

Optional Feature:
- MAJORITY_MASK_EN defined: channels with FAULT[i]=1 are excluded from the vote.
  - M = number of non-faulted channels.
  - vote[b] = 1 iff 2*(ones among non-faulted) > M; a tie resolves to 0.
  - If M = 0, vote = 0.
  - Faulted channels still produce DISAGREE bits against the masked vote, but their PC is frozen.
- MAJORITY_MASK_EN undefined: all N channels always vote; FAULT is report-only.

Test Plan (N=3, W=8, FAULT_TH=4, CNT_W=16):
- Reset then VALID with DIN = {8'h5A, 8'h5A, 8'h5A} -> next cycle MAJO=8'h5A, MAJO_VALID=1, DISAGREE=3'b000, ERR_CNT=0.
- Bitwise split, ch0=8'hF0, ch1=8'hCC, ch2=8'hAA -> MAJO=8'hE8, DISAGREE=3'b111, ERR_CNT=1.
- ch2=8'h00 with ch0=ch1=8'hFF for 4 consecutive VALIDs:
  - FAULT stays 3'b000 after 3 samples.
  - FAULT=3'b100 after the 4th.
  - FAULT stays set after ch2 later matches.
  - ERR_CNT=4.
- 3 mismatches on ch1, one matching sample, then 3 mismatches -> FAULT stays 0.
- VALID with mismatch in the same cycle as CLR_FAULT=1 -> MAJO updates; FAULT=0, ERR_CNT=0, PC=0 afterwards.
- Assert RST mid-stream -> all outputs 0 asynchronously, before the next clock edge.
- With MAJORITY_MASK_EN, after ch2 is faulted: ch0=8'hFF, ch1=8'h00, ch2=8'hFF -> tie resolves to MAJO=8'h00.
